// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 channel mux: steps the select, samples the mux output, and returns a parallel word over valid/ready.
// Optional SCAN_MASK_EN adds ch_mask so that disabled channels are skipped and read back as 0.
module mux_scan_ctrl #(
  parameter int SEL_W  = 3,
  parameter int NUM_CH = 2**SEL_W,
  parameter bit CONT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              y,
`ifdef SCAN_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  input  logic              ready,
  output logic [SEL_W-1:0]  s,
  output logic              busy,
  output logic [NUM_CH-1:0] data_out,
  output logic              valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_HOLD} state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_cnt;
  logic [NUM_CH-1:0]   r_shadow;
  logic [NUM_CH-1:0]   r_data;
  logic                r_valid;
  logic                r_busy;

  logic [NUM_CH-1:0]   w_start_mask;
  logic [NUM_CH-1:0]   w_run_mask;
  logic [SEL_W:0]      w_first;
  logic [SEL_W:0]      w_next;
  logic [NUM_CH-1:0]   w_word;
  logic                w_go;
  logic                w_launch;

  // Lowest enabled channel strictly above 'after'; MSB of the result flags that one exists.
  function automatic logic [SEL_W:0] f_next_ch(input logic [NUM_CH-1:0] mask, input int after);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (i > after && mask[i]) res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction

`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]   r_mask;
  assign w_start_mask = ch_mask;
  assign w_run_mask   = r_mask;
`else
  assign w_start_mask = '1;
  assign w_run_mask   = '1;
`endif

  assign w_first  = f_next_ch(w_start_mask, -1);
  assign w_next   = f_next_ch(w_run_mask, int'(r_cnt));
  assign w_go     = start | CONT;
  assign w_launch = w_go & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & ready));

  // Final word: skipped channels stay 0 because the shadow is cleared when a scan is launched.
  always_comb begin
    w_word        = r_shadow;
    w_word[r_cnt] = y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef SCAN_MASK_EN
      r_mask   <= '0;
`endif
    end else if (w_launch) begin
`ifdef SCAN_MASK_EN
      r_mask   <= ch_mask;
`endif
      r_shadow <= '0;
      if (w_first[SEL_W]) begin
        r_state <= ST_SCAN;
        r_cnt   <= w_first[SEL_W-1:0];
        r_busy  <= 1'b1;
        r_valid <= 1'b0;
      end else begin
        // No channel enabled: the word is complete immediately.
        r_state <= ST_HOLD;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_data  <= '0;
        r_valid <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_SCAN: begin
          r_shadow[r_cnt] <= y;
          if (w_next[SEL_W]) begin
            r_cnt <= w_next[SEL_W-1:0];
          end else begin
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s        = r_cnt;
  assign busy     = r_busy;
  assign data_out = r_data;
  assign valid    = r_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a mux model feeds y from s, and a scoreboard checks the words that are handed off.
// A second instance with CONT=1 is checked for continuous word production.
module tb_mux_scan_ctrl;
  localparam int SEL_W  = 3;
  localparam int NUM_CH = 8;

  logic              clk = 1'b0;
  logic              rst, start, ready, ready_c;
  logic [NUM_CH-1:0] r_x, r_x_c, mask_in;
  logic [SEL_W-1:0]  s, s_c;
  logic              busy, valid, busy_c, valid_c;
  logic [NUM_CH-1:0] data_out, data_c;
  logic              w_y, w_y_c;

  int                n_err = 0;
  int                n_chk = 0;
  int                last_c, n_words;
  logic [NUM_CH-1:0] sb [$];
  logic [NUM_CH-1:0] last_word;

  assign w_y   = r_x[s];
  assign w_y_c = r_x_c[s_c];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.SEL_W(SEL_W), .NUM_CH(NUM_CH), .CONT(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .y(w_y),
`ifdef SCAN_MASK_EN
    .ch_mask(mask_in),
`endif
    .ready(ready), .s(s), .busy(busy), .data_out(data_out), .valid(valid)
  );

  mux_scan_ctrl #(.SEL_W(SEL_W), .NUM_CH(NUM_CH), .CONT(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(1'b0), .y(w_y_c),
`ifdef SCAN_MASK_EN
    .ch_mask(8'hFF),
`endif
    .ready(ready_c), .s(s_c), .busy(busy_c), .data_out(data_c), .valid(valid_c)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [NUM_CH-1:0] xv, input logic [NUM_CH-1:0] m);
    r_x     = xv;
    mask_in = m;
    start   = 1'b1;
    sb.push_back(xv & m);
    tick();
    start   = 1'b0;
  endtask

  // Walks the enabled channels in ascending order; optionally pulses start mid-scan, which must be ignored.
  task automatic track_scan(input logic [NUM_CH-1:0] m, input bit poke);
    int k;
    k = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (m[ch]) begin
        chk("sel", 32'(s), ch);
        chk("busy", 32'(busy), 1);
        chk("valid_early", 32'(valid), 0);
        if (poke && k == 2) start = 1'b1;
        tick();
        start = 1'b0;
        k++;
      end
    end
    chk("valid_done", 32'(valid), 1);
    chk("busy_done", 32'(busy), 0);
    chk("sel_done", 32'(s), 0);
  endtask

  task automatic accept();
    logic [NUM_CH-1:0] exp;
    chk("valid_acc", 32'(valid), 1);
    if (sb.size() == 0) begin
      chk("sb_size", 32'(sb.size()), 1);
    end else begin
      exp = sb.pop_front();
      chk("data", 32'(data_out), 32'(exp));
      last_word = exp;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; ready = 1'b1; ready_c = 1'b1;
    r_x = '0; r_x_c = 8'h96; mask_in = 8'hFF; last_word = '0;

    // Reset held with start asserted: reset wins.
    repeat (2) begin
      tick();
      chk("rst_s", 32'(s), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_data", 32'(data_out), 0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    chk("idle_s", 32'(s), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(valid), 0);
    chk("idle_data", 32'(data_out), 0);

    // Basic scan with backpressure; a stray start mid-scan is ignored.
    ready = 1'b0;
    start_scan(8'hA5, 8'hFF);
    track_scan(8'hFF, 1'b1);
    r_x = 8'h3C;
    repeat (5) begin
      tick();
      chk("hold_valid", 32'(valid), 1);
      chk("hold_data", 32'(data_out), 32'hA5);
    end

    // Accept and relaunch on the same edge: no idle bubble.
    accept();
    ready = 1'b1;
    start_scan(8'h3C, 8'hFF);
    chk("b2b_valid_drop", 32'(valid), 0);
    track_scan(8'hFF, 1'b0);
    accept();
    start_scan(8'h5A, 8'hFF);
    track_scan(8'hFF, 1'b0);
    accept();
    tick();
    chk("ret_valid", 32'(valid), 0);
    chk("ret_busy", 32'(busy), 0);
    chk("ret_data", 32'(data_out), 32'(last_word));
    tick();
    chk("ret_idle_busy", 32'(busy), 0);

    // Abort mid-scan.
    start_scan(8'hFF, 8'hFF);
    repeat (3) tick();
    chk("abort_pre_s", 32'(s), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", 32'(busy), 0);
    chk("abort_s", 32'(s), 0);
    chk("abort_valid", 32'(valid), 0);
    chk("abort_data", 32'(data_out), 0);
    repeat (10) begin
      tick();
      chk("abort_no_valid", 32'(valid), 0);
      chk("abort_no_busy", 32'(busy), 0);
    end
    start_scan(8'hFF, 8'hFF);
    track_scan(8'hFF, 1'b0);
    accept();
    tick();

`ifdef SCAN_MASK_EN
    start_scan(8'hFF, 8'b1000_0101);
    track_scan(8'b1000_0101, 1'b0);
    accept();
    tick();
    start_scan(8'hFF, 8'h00);
    track_scan(8'h00, 1'b0);
    accept();
    tick();
`endif

    // Continuous instance: a word every 9 cycles with ready held high.
    last_c  = -1;
    n_words = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (valid_c) begin
        chk("cont_data", 32'(data_c), 32'h96);
        chk("cont_busy", 32'(busy_c), 0);
        if (last_c >= 0) chk("cont_gap", 32'(c - last_c), 9);
        last_c = c;
        n_words++;
      end
    end
    chk("cont_words", 32'(n_words >= 4), 1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
